ex_mem_pipe: RTL and testbench

//  - EX->MEM pipeline stage. Registers ALU result, flags and writeback/memory control for the MEM stage.
//  - Sits directly downstream of the ALU.
//  - 2-entry skid buffer: main + skid register.
//    - Full throughput with valid/ready on both sides.
//    - ex_ready is driven straight from a flop, so there is no combinational ready path back into EX.

---
 rtl/ex_mem_pipe.sv | 179 +++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// EX->MEM pipeline register built as a 2-entry skid buffer (main + skid).
// It accepts one entry per cycle in both directions at full throughput. ex_ready
// comes straight from a flop, so no combinational ready path runs back into EX.
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   flush             synchronous kill of every buffered entry
//   ex_*              upstream entry: valid/ready, result, flags {V,C,N,Z}, rd,
//                     reg_write, mem_read, mem_write, store_data
//   mem_*             downstream entry: valid/ready plus registered payload copies
//   stall_count,      (only with EXMEM_PERF_CNT_EN) saturating counters of
//   xfer_count        backpressure cycles and completed drains
//
// Optional feature macro: EXMEM_PERF_CNT_EN
module ex_mem_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [3:0]            ex_flags,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [XLEN-1:0]       ex_store_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [XLEN-1:0]       mem_result,
  output logic [3:0]            mem_flags,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [XLEN-1:0]       mem_store_data
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           xfer_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [3:0]            flags;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [XLEN-1:0]       store_data;
  } payload_t;

  state_e   state_q;
  logic     ex_ready_q;
  logic     mem_valid_q;
  payload_t main_q;
  payload_t skid_q;
  payload_t in_d;
  logic     accept;
  logic     drain;

  assign accept = ex_valid & ex_ready_q;
  assign drain  = mem_valid_q & mem_ready;

  // Writes to x0 are architecturally discarded, so the enable is cleared on entry.
  always_comb begin
    in_d            = '0;
    in_d.result     = ex_result;
    in_d.flags      = ex_flags;
    in_d.rd         = ex_rd;
    in_d.reg_write  = ex_reg_write & (ex_rd != '0);
    in_d.mem_read   = ex_mem_read;
    in_d.mem_write  = ex_mem_write;
    in_d.store_data = ex_store_data;
  end

  // Occupancy FSM; ex_ready and mem_valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      // Any accept or drain seen in this cycle is discarded along with the contents.
      state_q     <= EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_d;
            state_q     <= MAIN;
            mem_valid_q <= 1'b1;
          end
        end
        MAIN: begin
          if (accept && drain) begin
            main_q <= in_d;
          end else if (accept) begin
            // MEM is stalled: park the new entry behind the one on the outputs.
            skid_q     <= in_d;
            state_q    <= FULL;
            ex_ready_q <= 1'b0;
          end else if (drain) begin
            state_q     <= EMPTY;
            mem_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= MAIN;
            ex_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          ex_ready_q  <= 1'b1;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready       = ex_ready_q;
  assign mem_valid      = mem_valid_q;
  assign mem_result     = main_q.result;
  assign mem_flags      = main_q.flags;
  assign mem_rd         = main_q.rd;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_store_data = main_q.store_data;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] xfer_q, xfer_d;

  // Both counters saturate and survive flush; a flushed drain never reached MEM.
  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (mem_valid_q && !mem_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (drain && !flush && (xfer_q != 32'hFFFF_FFFF)) begin
      xfer_d = xfer_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stall_count = stall_q;
  assign xfer_count  = xfer_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [3:0]  ex_flags;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [3:0]  mem_flags;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [31:0] mem_store_data;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] xfer_count;
`endif

  int nvec = 0;
  int errs = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_flags(ex_flags), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_flags(mem_flags), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_count(stall_count), .xfer_count(xfer_count)
`endif
  );

  // Reference model: an ordered queue of at most two entries.
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } ent_t;

  ent_t q[$];
  bit   m_acc, m_drn;
  ent_t m_in;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      m_acc = ex_valid && (q.size() < 2);
      m_drn = (q.size() > 0) && mem_ready;
      m_in  = '{res: ex_result, fl: ex_flags, rd: ex_rd,
                rw: ex_reg_write && (ex_rd != 5'd0),
                mr: ex_mem_read, mw: ex_mem_write, sd: ex_store_data};
      if (flush) begin
        q.delete();
      end else begin
        if (m_drn) void'(q.pop_front());
        if (m_acc) q.push_back(m_in);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of handshake and head-of-queue payload.
  ent_t act_e;
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("model_valid", {63'd0, mem_valid}, {63'd0, q.size() > 0});
      chk("model_ready", {63'd0, ex_ready}, {63'd0, q.size() < 2});
      if (q.size() > 0) begin
        act_e = '{res: mem_result, fl: mem_flags, rd: mem_rd, rw: mem_reg_write,
                  mr: mem_mem_read, mw: mem_mem_write, sd: mem_store_data};
        nvec++;
        if (act_e !== q[0]) begin
          errs++;
          $display("FAIL model_payload: got %0h expected %0h at %0t", act_e, q[0], $time);
        end
      end
    end
  end

  task automatic put(input logic v, input logic [31:0] r, input logic [3:0] f,
                     input logic [4:0] d, input logic rw, input logic mr,
                     input logic mw, input logic [31:0] sd);
    ex_valid      = v;
    ex_result     = r;
    ex_flags      = f;
    ex_rd         = d;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_store_data = sd;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_result", {32'd0, mem_result}, 64'd0);
    rst = 1'b0;
    run_chk = 1'b1;

    // Single transfer
    mem_ready = 1'b1;
    put(1, 32'h0000_0005, 4'b0000, 5'd3, 1, 0, 0, 32'h0);
    @(negedge clk);
    chk("single_valid", {63'd0, mem_valid}, 64'd1);
    chk("single_result", {32'd0, mem_result}, 64'h5);
    chk("single_rd", {59'd0, mem_rd}, 64'd3);
    chk("single_rw", {63'd0, mem_reg_write}, 64'd1);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_empty", {63'd0, mem_valid}, 64'd0);

    // Backpressure
    mem_ready = 1'b0;
    put(1, 32'h11, 4'h1, 5'd1, 1, 1, 0, 32'hA);
    @(negedge clk);
    put(1, 32'h22, 4'h2, 5'd2, 0, 0, 1, 32'hB);
    @(negedge clk);
    chk("bp_result_a", {32'd0, mem_result}, 64'h11);
    put(1, 32'h33, 4'h4, 5'd7, 1, 0, 0, 32'hC);
    @(negedge clk);
    chk("bp_ready_full", {63'd0, ex_ready}, 64'd0);
    chk("bp_hold1", {32'd0, mem_result}, 64'h11);
    @(negedge clk);
    chk("bp_hold2", {32'd0, mem_result}, 64'h11);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_b", {32'd0, mem_result}, 64'h22);
    chk("bp_ready_back", {63'd0, ex_ready}, 64'd1);
    @(negedge clk);
    chk("bp_out_c", {32'd0, mem_result}, 64'h33);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_empty", {63'd0, mem_valid}, 64'd0);

    // Streaming
    for (int i = 0; i < 100; i++) begin
      put(1, 32'(i), 4'(i), 5'((i % 31) + 1), 1, 1'(i % 2), 1'(i % 3 == 0), 32'(i * 7));
      @(negedge clk);
      chk("stream_result", {32'd0, mem_result}, 64'(i));
      chk("stream_ready", {63'd0, ex_ready}, 64'd1);
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stream_empty", {63'd0, mem_valid}, 64'd0);

    // Flush while FULL with a concurrent offer
    mem_ready = 1'b0;
    put(1, 32'hA1, 4'h3, 5'd4, 1, 0, 0, 32'h1);
    @(negedge clk);
    put(1, 32'hB2, 4'h5, 5'd5, 1, 0, 1, 32'h2);
    @(negedge clk);
    put(1, 32'hC3, 4'h6, 5'd6, 1, 1, 0, 32'h3);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", {63'd0, mem_valid}, 64'd0);
    chk("flush_ready", {63'd0, ex_ready}, 64'd1);
    flush = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_c_dropped", {63'd0, mem_valid}, 64'd0);

    // x0 destination and flag pass-through
    mem_ready = 1'b1;
    put(1, 32'h8000_0000, 4'b1110, 5'd0, 1, 1, 0, 32'h55);
    @(negedge clk);
    chk("x0_rw", {63'd0, mem_reg_write}, 64'd0);
    chk("x0_flags", {60'd0, mem_flags}, 64'he);
    chk("x0_result", {32'd0, mem_result}, 64'h8000_0000);
    chk("x0_memread", {63'd0, mem_mem_read}, 64'd1);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Asynchronous reset while FULL
    mem_ready = 1'b0;
    put(1, 32'h1, 4'h0, 5'd8, 1, 0, 0, 32'h0);
    @(negedge clk);
    put(1, 32'h2, 4'h0, 5'd9, 1, 0, 0, 32'h0);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ar_full", {63'd0, ex_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, mem_valid}, 64'd0);
    chk("ar_ready", {63'd0, ex_ready}, 64'd1);
    chk("ar_result", {32'd0, mem_result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef EXMEM_PERF_CNT_EN
    chk("perf_stall0", {32'd0, stall_count}, 64'd0);
    chk("perf_xfer0", {32'd0, xfer_count}, 64'd0);
    mem_ready = 1'b0;
    put(1, 32'h77, 4'h0, 5'd1, 1, 0, 0, 32'h0);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("perf_stall", {32'd0, stall_count}, 64'd5);
    chk("perf_xfer", {32'd0, xfer_count}, 64'd1);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
